regfile: RTL and testbench



---
 rtl/regfile.sv | 87 ++++++++
 tb/tb_regfile.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
//
// General-purpose register file for the 5-stage MIPS core.
// It holds 2^ADDR_WIDTH registers of DATA_WIDTH bits each.
// Register 0 is hardwired to zero: it is never written and always reads 0.
//
// The MEM/WB stage drives the write side. The ID stage reads through two
// independent, fully combinational read ports. A same-cycle write-to-read
// bypass lets the ID stage see the value being written back in this cycle.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   rst            synchronous reset, active-high; clears every entry
//   w_reg_addr_in  writeback destination register (from MEM/WB)
//   w_reg_data_in  writeback data (from MEM/WB)
//   w_reg_en_in    writeback enable (from MEM/WB)
//   r1_en          read port 1 enable
//   r1_addr        read port 1 address
//   r1_data        read port 1 data (zero-cycle latency)
//   r2_en          read port 2 enable
//   r2_addr        read port 2 address
//   r2_data        read port 2 data (zero-cycle latency)
// ----------------------------------------------------------------------------
module regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] w_reg_addr_in,
    input  logic [DATA_WIDTH-1:0] w_reg_data_in,
    input  logic                  w_reg_en_in,
    input  logic                  r1_en,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    output logic [DATA_WIDTH-1:0] r1_data,
    input  logic                  r2_en,
    input  logic [ADDR_WIDTH-1:0] r2_addr,
    output logic [DATA_WIDTH-1:0] r2_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage update. Reset takes priority, so a write that arrives on the
    // reset edge is dropped. Writes to register 0 are also dropped, which
    // keeps entry 0 at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (w_reg_en_in && (w_reg_addr_in != '0)) begin
            mem[w_reg_addr_in] <= w_reg_data_in;
        end
    end

    // Read-port selection, highest priority first: reset, disabled port,
    // register 0, then the writeback bypass, then storage. The bypass gives
    // write-first behaviour. w_reg_* comes straight from MEM/WB flops, so this
    // path cannot close a combinational loop through the ID stage.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic                  en,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (rst || !en || (addr == '0)) begin
            value = '0;
        end else if (w_reg_en_in && (w_reg_addr_in == addr)) begin
            value = w_reg_data_in;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Both ports are independent copies of the same selection logic. They may
    // address the same register in the same cycle, including the bypassed one.
    always_comb begin
        r1_data = read_port(r1_en, r1_addr, mem[r1_addr]);
        r2_data = read_port(r2_en, r2_addr, mem[r2_addr]);
    end

endmodule

// File: tb/tb_regfile.sv
// ----------------------------------------------------------------------------
// tb_regfile
//
// Scoreboard testbench for regfile.
//
// The driver applies one set of inputs per cycle. For each set it queues the
// read values that the reference model predicts. The model is a plain array
// plus the read-priority rules.
//
// A separate monitor pops one expectation at every falling edge and compares
// it with both read ports.
// ----------------------------------------------------------------------------
module tb_regfile;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NREG = 1 << AW;

    logic          clk;
    logic          rst;
    logic [AW-1:0] w_reg_addr_in;
    logic [DW-1:0] w_reg_data_in;
    logic          w_reg_en_in;
    logic          r1_en;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_data;
    logic          r2_en;
    logic [AW-1:0] r2_addr;
    logic [DW-1:0] r2_data;

    typedef struct {
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
        string         name;
    } expect_t;

    expect_t       sb[$];
    logic [DW-1:0] model_mem [NREG];
    int            total;
    int            bad;

    regfile #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_reg_addr_in(w_reg_addr_in),
        .w_reg_data_in(w_reg_data_in),
        .w_reg_en_in  (w_reg_en_in),
        .r1_en        (r1_en),
        .r1_addr      (r1_addr),
        .r1_data      (r1_data),
        .r2_en        (r2_en),
        .r2_addr      (r2_addr),
        .r2_data      (r2_data)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference read for one port.
    // A register reads the value being written to it this cycle if there is
    // one, otherwise what was last stored. Reset, a disabled port and
    // register 0 all read as zero.
    function automatic logic [DW-1:0] model_read(
        input logic          r,
        input logic          en,
        input logic [AW-1:0] addr,
        input logic          we,
        input logic [AW-1:0] waddr,
        input logic [DW-1:0] wdata
    );
        if (r || !en || addr == 0) return '0;
        if (we && waddr == addr) return wdata;
        return model_mem[addr];
    endfunction

    // Drive one cycle's inputs shortly after the rising edge.
    // Then queue the predicted read values.
    // Then update the model for the edge that will close this cycle.
    task automatic applyStimulus(
        input logic          r,
        input logic          we,
        input logic [AW-1:0] waddr,
        input logic [DW-1:0] wdata,
        input logic          e1,
        input logic [AW-1:0] a1,
        input logic          e2,
        input logic [AW-1:0] a2,
        input string         name
    );
        expect_t item;
        @(posedge clk);
        #1;
        rst           = r;
        w_reg_en_in   = we;
        w_reg_addr_in = waddr;
        w_reg_data_in = wdata;
        r1_en         = e1;
        r1_addr       = a1;
        r2_en         = e2;
        r2_addr       = a2;
        item.exp1 = model_read(r, e1, a1, we, waddr, wdata);
        item.exp2 = model_read(r, e2, a2, we, waddr, wdata);
        item.name = name;
        sb.push_back(item);
        if (r) begin
            for (int i = 0; i < NREG; i++) model_mem[i] = '0;
        end else if (we && waddr != 0) begin
            model_mem[waddr] = wdata;
        end
    endtask

    task automatic checkOutput(input expect_t item);
        total++;
        if (r1_data !== item.exp1) begin
            bad++;
            $display("[TB] FAIL %s r1_data got=%h want=%h", item.name, r1_data, item.exp1);
        end
        total++;
        if (r2_data !== item.exp2) begin
            bad++;
            $display("[TB] FAIL %s r2_data got=%h want=%h", item.name, r2_data, item.exp2);
        end
    endtask

    // Monitor: the read ports are valid every cycle, so one expectation is
    // consumed at each falling edge once the driver has started.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #500000;
        bad++;
        $display("[TB] FAIL watchdog timeout got=expired want=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic          we;
        logic          e1;
        logic          e2;
        logic          r;
        logic [AW-1:0] wa;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] wd;

        total = 0;
        bad   = 0;
        for (int i = 0; i < NREG; i++) model_mem[i] = '0;
        rst = 1'b1;
        w_reg_en_in = 1'b0;
        w_reg_addr_in = '0;
        w_reg_data_in = '0;
        r1_en = 1'b0;
        r1_addr = '0;
        r2_en = 1'b0;
        r2_addr = '0;

        $display("[TB] initial reset");
        applyStimulus(1, 0, 0, 0, 1, 3, 1, 4, "reset_init");

        $display("[TB] reset clear");
        for (int i = 1; i < NREG; i++) begin
            applyStimulus(0, 1, AW'(i), 32'hA5A5_0000 + DW'(i), 0, 0, 0, 0, "preload");
        end
        applyStimulus(0, 0, 0, 0, 1, 5, 1, 31, "preload_check");
        applyStimulus(1, 0, 0, 0, 1, 5, 1, 31, "reset_outputs_zero");
        for (int i = 0; i < NREG; i++) begin
            applyStimulus(0, 0, 0, 0, 1, AW'(i), 1, AW'(NREG - 1 - i), "reset_cleared");
        end

        $display("[TB] write/read basic");
        applyStimulus(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, "write_r5");
        applyStimulus(0, 0, 0, 0, 1, 5, 1, 5, "read_r5");
        applyStimulus(0, 0, 0, 0, 0, 5, 0, 5, "read_r5_disabled");

        $display("[TB] zero register");
        applyStimulus(0, 1, 0, 32'h1234_5678, 1, 0, 1, 0, "write_r0_same");
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, "write_r0_next");
        for (int i = 1; i < NREG; i++) begin
            applyStimulus(0, 0, 0, 0, 1, AW'(i), 1, AW'(i), "r0_others_intact");
        end

        $display("[TB] bypass");
        applyStimulus(0, 1, 7, 32'h1111_1111, 0, 0, 0, 0, "r7_init");
        applyStimulus(0, 1, 7, 32'h2222_2222, 1, 7, 1, 7, "bypass_same");
        applyStimulus(0, 0, 7, 32'h3333_3333, 1, 7, 1, 7, "bypass_next");
        applyStimulus(0, 1, 7, 32'h1111_1111, 0, 0, 0, 0, "r7_restore");
        applyStimulus(0, 0, 7, 32'h2222_2222, 1, 7, 1, 7, "no_bypass_when_off");

        $display("[TB] reset vs write collision");
        applyStimulus(1, 1, 9, 32'hFFFF_FFFF, 1, 9, 1, 9, "rst_write_collide");
        applyStimulus(0, 0, 0, 0, 1, 9, 1, 9, "r9_after_rst");
        applyStimulus(0, 1, 9, 32'hCAFE_0009, 0, 0, 0, 0, "post_rst_write");
        applyStimulus(0, 0, 0, 0, 1, 9, 1, 9, "post_rst_read");

        $display("[TB] back-to-back writes");
        applyStimulus(0, 1, 12, 32'h0000_00AA, 0, 0, 0, 0, "b2b_first");
        applyStimulus(0, 1, 12, 32'h0000_00BB, 0, 0, 0, 0, "b2b_second");
        applyStimulus(0, 0, 0, 0, 1, 12, 1, 12, "b2b_last_wins");

        $display("[TB] random regression");
        for (int n = 0; n < 10000; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            we = ($urandom_range(0, 3) != 0);
            wa = AW'($urandom_range(0, NREG - 1));
            wd = DW'($urandom);
            e1 = ($urandom_range(0, 7) != 0);
            e2 = ($urandom_range(0, 7) != 0);
            a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
            a2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
            applyStimulus(r, we, wa, wd, e1, a1, e2, a2, "random");
        end

        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
